// File: rtl/vector_add_arbiter_if.sv
// Bundle of client request/operand/result signals and adder handshake signals for vector_add_arbiter.
// master: the arbiter's view; slave: the clients and adder side.
interface vector_add_arbiter_if #(
    parameter int IN_WIDTH = 10
);
    localparam int vecWidth  = 10 * IN_WIDTH;
    localparam int sumWidth  = 10 * (IN_WIDTH + 1);
    localparam int halfWidth = 5 * (IN_WIDTH + 1);

    logic                 req0;
    logic                 req1;
    logic [vecWidth-1:0]  a0_bus;
    logic [vecWidth-1:0]  b0_bus;
    logic [vecWidth-1:0]  a1_bus;
    logic [vecWidth-1:0]  b1_bus;
    logic                 ack0;
    logic                 ack1;
    logic                 add_ready;
    logic                 add_in_ready;
    logic [vecWidth-1:0]  add_a;
    logic [vecWidth-1:0]  add_b;
    logic                 add_out_ready;
    logic                 add_out_series;
    logic [halfWidth-1:0] add_s;
    logic                 res_valid0;
    logic                 res_valid1;
    logic [sumWidth-1:0]  res_s;
    logic                 busy;

    modport master (
        input  req0, req1, a0_bus, b0_bus, a1_bus, b1_bus,
        input  add_ready, add_out_ready, add_out_series, add_s,
        output ack0, ack1, add_in_ready, add_a, add_b,
        output res_valid0, res_valid1, res_s, busy
    );

    modport slave (
        output req0, req1, a0_bus, b0_bus, a1_bus, b1_bus,
        output add_ready, add_out_ready, add_out_series, add_s,
        input  ack0, ack1, add_in_ready, add_a, add_b,
        input  res_valid0, res_valid1, res_s, busy
    );
endinterface

// File: rtl/vector_add_arbiter.sv
// Round-robin arbiter sharing one two-half vector adder between two clients.
// Optional watchdog on the adder response: define VECTOR_ADD_ARBITER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no operation outstanding; grant when a client requests and the adder is ready
// ISSUE   | operands captured and acked; next edge pulses add_in_ready
// WAIT_LO | waiting for the half-result of elements 0-4
// WAIT_HI | waiting for the half-result of elements 5-9
// DONE    | result assembled; res_valid of the owner is high, round-robin pointer updates
module vector_add_arbiter #(
    parameter int IN_WIDTH       = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    vector_add_arbiter_if.master bus
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);
    localparam int vecWidth  = 10 * IN_WIDTH;
    localparam int sumWidth  = 10 * (IN_WIDTH + 1);
    localparam int halfWidth = 5 * (IN_WIDTH + 1);

    if (IN_WIDTH < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadParams
        $error("vector_add_arbiter: IN_WIDTH must be >= 1 and TIMEOUT_CYCLES within 1..255");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} stateT;

    stateT                state, stateNext;
    logic                 lastGrant, lastGrantNext;
    logic                 owner, ownerNext;
    logic                 grantSel;
    logic [vecWidth-1:0]  addA, addANext, addB, addBNext;
    logic [sumWidth-1:0]  resS, resSNext;
    logic                 ack0Q, ack0Next, ack1Q, ack1Next;
    logic                 inReadyQ, inReadyNext;
    logic                 valid0Q, valid0Next, valid1Q, valid1Next;

`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
    localparam logic [7:0] wdogLoad = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wdog, wdogNext;
    logic       timeoutQ, timeoutNext;
`endif

    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        ownerNext     = owner;
        addANext      = addA;
        addBNext      = addB;
        resSNext      = resS;
        ack0Next      = 1'b0;
        ack1Next      = 1'b0;
        inReadyNext   = 1'b0;
        valid0Next    = 1'b0;
        valid1Next    = 1'b0;
        // lastGrant holds the client served last, so a contested grant goes to the other one
        grantSel      = (bus.req0 & bus.req1) ? ~lastGrant : bus.req1;

        case (state)
            IDLE: begin
                if ((bus.req0 | bus.req1) && bus.add_ready) begin
                    ownerNext = grantSel;
                    addANext  = grantSel ? bus.a1_bus : bus.a0_bus;
                    addBNext  = grantSel ? bus.b1_bus : bus.b0_bus;
                    ack0Next  = ~grantSel;
                    ack1Next  = grantSel;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                inReadyNext = 1'b1;
                stateNext   = WAIT_LO;
            end
            WAIT_LO: begin
                if (bus.add_out_ready && !bus.add_out_series) begin
                    resSNext[halfWidth-1:0] = bus.add_s;
                    stateNext               = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.add_out_ready && bus.add_out_series) begin
                    resSNext[sumWidth-1 -: halfWidth] = bus.add_s;
                    valid0Next = ~owner;
                    valid1Next = owner;
                    stateNext  = DONE;
                end
            end
            DONE: begin
                lastGrantNext = owner;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase

`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
        wdogNext    = '0;
        timeoutNext = 1'b0;
        if (state == ISSUE) begin
            wdogNext = wdogLoad;
        end else if (state == WAIT_LO || state == WAIT_HI) begin
            // a state change here means a strobe was accepted, which restarts the watchdog
            if (stateNext != state) begin
                wdogNext = wdogLoad;
            end else if (wdog == 8'd0) begin
                stateNext   = IDLE;
                timeoutNext = 1'b1;
            end else begin
                wdogNext = wdog - 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            addA      <= '0;
            addB      <= '0;
            resS      <= '0;
            ack0Q     <= 1'b0;
            ack1Q     <= 1'b0;
            inReadyQ  <= 1'b0;
            valid0Q   <= 1'b0;
            valid1Q   <= 1'b0;
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
            wdog      <= '0;
            timeoutQ  <= 1'b0;
`endif
        end else if (enable) begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            owner     <= ownerNext;
            addA      <= addANext;
            addB      <= addBNext;
            resS      <= resSNext;
            ack0Q     <= ack0Next;
            ack1Q     <= ack1Next;
            inReadyQ  <= inReadyNext;
            valid0Q   <= valid0Next;
            valid1Q   <= valid1Next;
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
            wdog      <= wdogNext;
            timeoutQ  <= timeoutNext;
`endif
        end
    end

    // pulses are masked while stalled so a frozen cycle never shows a stretched pulse
    assign bus.ack0         = ack0Q & enable;
    assign bus.ack1         = ack1Q & enable;
    assign bus.add_in_ready = inReadyQ & enable;
    assign bus.res_valid0   = valid0Q & enable;
    assign bus.res_valid1   = valid1Q & enable;
    assign bus.add_a        = addA;
    assign bus.add_b        = addB;
    assign bus.res_s        = resS;
    assign bus.busy         = (state != IDLE);
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
    assign timeout_err      = timeoutQ & enable;
`endif
endmodule

// File: tb/tb_vector_add_arbiter.sv
// Bench for vector_add_arbiter: directed scenarios with literal expectations plus a
// transaction-level reference model compared against the outputs on every falling edge.
`timescale 1ns/1ps
module tb_vector_add_arbiter;
    localparam int W  = 10;
    localparam int VW = 10 * W;
    localparam int SW = 10 * (W + 1);
    localparam int HW = 5 * (W + 1);
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    always #5 clk = ~clk;

    vector_add_arbiter_if #(.IN_WIDTH(W)) bus ();
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
    logic timeout_err;
`endif

    vector_add_arbiter #(.IN_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus)
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit checkOn = 0;

    task automatic check(string name, logic [SW-1:0] act, logic [SW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failTimeout(string name);
        total++;
        bad++;
        $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
    endtask

    function automatic logic [VW-1:0] fillVec(int v);
        logic [VW-1:0] r;
        for (int k = 0; k < 10; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [SW-1:0] fillSum(int v);
        logic [SW-1:0] r;
        for (int k = 0; k < 10; k++) r[k*(W+1) +: W+1] = (W+1)'(v);
        return r;
    endfunction

    // elementwise signed sum; the true mathematical result the client should receive
    function automatic logic [SW-1:0] sumVec(logic [VW-1:0] a, logic [VW-1:0] b);
        logic [SW-1:0] r;
        for (int k = 0; k < 10; k++)
            r[k*(W+1) +: W+1] = $signed(a[k*W +: W]) + $signed(b[k*W +: W]);
        return r;
    endfunction

    // reference model: one outstanding operation walking grant -> issue -> lo half -> hi half -> retire
    int            stage = 0;
    bit            mOwner = 0;
    bit            mPrefer = 0;
    logic [VW-1:0] eA = '0, eB = '0;
    logic [SW-1:0] eSum = '0;
    bit            eAck0 = 0, eAck1 = 0, eInRdy = 0, eVal0 = 0, eVal1 = 0;
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
    int            wd = 0;
    bit            eTo = 0;
`endif

    always @(posedge clk) begin
        eAck0 = 0; eAck1 = 0; eInRdy = 0; eVal0 = 0; eVal1 = 0;
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
        eTo = 0;
`endif
        if (reset) begin
            stage = 0; mPrefer = 0; mOwner = 0; eA = '0; eB = '0;
        end else if (enable) begin
            case (stage)
                0: if ((bus.req0 || bus.req1) && bus.add_ready) begin
                    mOwner = (bus.req0 && bus.req1) ? mPrefer : bus.req1;
                    eA = mOwner ? bus.a1_bus : bus.a0_bus;
                    eB = mOwner ? bus.b1_bus : bus.b0_bus;
                    eSum = sumVec(eA, eB);
                    if (mOwner) eAck1 = 1; else eAck0 = 1;
                    stage = 1;
                end
                1: begin
                    eInRdy = 1; stage = 2;
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
                    wd = 0;
`endif
                end
                2, 3: begin
                    if (bus.add_out_ready && (bus.add_out_series == (stage == 3))) begin
                        if (stage == 3) begin
                            if (mOwner) eVal1 = 1; else eVal0 = 1;
                            stage = 4;
                        end else begin
                            stage = 3;
                        end
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
                        wd = 0;
`endif
                    end else begin
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
                        wd++;
                        if (wd == TO) begin stage = 0; eTo = 1; end
`endif
                    end
                end
                4: begin mPrefer = !mOwner; stage = 0; end
                default: stage = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            check("ack0", bus.ack0, eAck0);
            check("ack1", bus.ack1, eAck1);
            check("add_in_ready", bus.add_in_ready, eInRdy);
            check("res_valid0", bus.res_valid0, eVal0);
            check("res_valid1", bus.res_valid1, eVal1);
            check("busy", bus.busy, stage != 0);
            if (stage != 0) begin
                check("add_a", bus.add_a, eA);
                check("add_b", bus.add_b, eB);
            end
            if (eVal0 || eVal1) check("res_s", bus.res_s, eSum);
`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
            check("timeout_err", timeout_err, eTo);
`endif
        end
    end

    task automatic waitAck(string name, output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack0) begin who = 0; return; end
            if (bus.ack1) begin who = 1; return; end
        end
        failTimeout(name);
    endtask

    task automatic waitInReady(string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.add_in_ready) return;
        end
        failTimeout(name);
    endtask

    // adder stand-in: called on the add_in_ready cycle; ends on the cycle res_valid is due
    task automatic adderRun(int lat, bit stray);
        logic [SW-1:0] s;
        repeat (lat) @(negedge clk);
        if (stray) begin
            bus.add_out_ready = 1; bus.add_out_series = 1; bus.add_s = '1;
            @(negedge clk);
        end
        s = sumVec(bus.add_a, bus.add_b);
        bus.add_out_ready = 1; bus.add_out_series = 0; bus.add_s = s[HW-1:0];
        @(negedge clk);
        bus.add_out_series = 1; bus.add_s = s[SW-1 -: HW];
        @(negedge clk);
        bus.add_out_ready = 0; bus.add_out_series = 0; bus.add_s = '0;
    endtask

    initial begin
        int who;
        logic [SW-1:0] exp;
        logic [VW-1:0] idx;

        reset = 1; enable = 1;
        bus.req0 = 0; bus.req1 = 0; bus.add_ready = 1;
        bus.a0_bus = '0; bus.b0_bus = '0; bus.a1_bus = '0; bus.b1_bus = '0;
        bus.add_out_ready = 0; bus.add_out_series = 0; bus.add_s = '0;
        repeat (2) @(negedge clk);
        checkOn = 1;
        check("rst_busy", bus.busy, 0);
        check("rst_add_a", bus.add_a, 0);
        check("rst_add_b", bus.add_b, 0);
        check("rst_res_s", bus.res_s, 0);
        reset = 0;

        // single client 0, operands 3 + 4, adder latency 2
        bus.a0_bus = fillVec(3); bus.b0_bus = fillVec(4); bus.req0 = 1;
        @(negedge clk);
        check("r33_ack0", bus.ack0, 1);
        bus.req0 = 0;
        @(negedge clk);
        check("r33_in_ready", bus.add_in_ready, 1);
        adderRun(2, 0);
        check("r33_valid0", bus.res_valid0, 1);
        exp = fillSum(7);
        check("r33_res", bus.res_s, exp);
        @(negedge clk);
        check("r33_res_held", bus.res_s, exp);

        // both clients contending from reset
        reset = 1; @(negedge clk); reset = 0;
        bus.a0_bus = fillVec(10);  bus.b0_bus = fillVec(-3);
        bus.a1_bus = fillVec(100); bus.b1_bus = fillVec(-200);
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 4; i++) begin
            waitAck("r34_ack", who);
            check("r34_order", who, i % 2);
            if (i == 3) begin bus.req0 = 0; bus.req1 = 0; end
            waitInReady("r34_in_ready");
            adderRun(1, 0);
            if (who == 1) begin
                check("r34_valid1", bus.res_valid1, 1);
                exp = fillSum(-100);
            end else begin
                check("r34_valid0", bus.res_valid0, 1);
                exp = fillSum(7);
            end
            check("r34_res", bus.res_s, exp);
        end

        // adder not ready holds off the grant
        bus.add_ready = 0; bus.req1 = 1;
        repeat (4) begin
            @(negedge clk);
            check("r35_no_ack1", bus.ack1, 0);
        end
        bus.add_ready = 1;
        @(negedge clk);
        check("r35_ack1", bus.ack1, 1);
        bus.req1 = 0;
        waitInReady("r35_in_ready");
        adderRun(3, 0);
        check("r35_valid1", bus.res_valid1, 1);

        // stray hi strobe while waiting for the lo half
        for (int k = 0; k < 10; k++) idx[k*W +: W] = W'(k);
        bus.a0_bus = fillVec(-5); bus.b0_bus = idx; bus.req0 = 1;
        waitAck("r36_ack", who);
        check("r36_who", who, 0);
        bus.req0 = 0;
        waitInReady("r36_in_ready");
        adderRun(1, 1);
        check("r36_valid0", bus.res_valid0, 1);
        for (int k = 0; k < 10; k++) exp[k*(W+1) +: W+1] = (W+1)'(k - 5);
        check("r36_res", bus.res_s, exp);

        // clock enable low freezes the arbiter
        @(negedge clk);
        enable = 0; bus.req0 = 1; bus.a0_bus = fillVec(1); bus.b0_bus = fillVec(2);
        repeat (3) begin
            @(negedge clk);
            check("en_no_ack0", bus.ack0, 0);
        end
        enable = 1;
        @(negedge clk);
        check("en_ack0", bus.ack0, 1);
        bus.req0 = 0;
        waitInReady("en_in_ready");
        adderRun(0, 0);
        check("en_valid0", bus.res_valid0, 1);
        exp = fillSum(3);
        check("en_res", bus.res_s, exp);

        // reset while waiting for the hi half abandons the operation
        bus.a1_bus = fillVec(50); bus.b1_bus = fillVec(60); bus.req1 = 1;
        waitAck("r37_ack", who);
        bus.req1 = 0;
        waitInReady("r37_in_ready");
        bus.add_out_ready = 1; bus.add_out_series = 0; bus.add_s = '1;
        @(negedge clk);
        bus.add_out_ready = 0;
        check("r37_busy_before", bus.busy, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("r37_busy", bus.busy, 0);
        check("r37_add_a", bus.add_a, 0);
        check("r37_res_s", bus.res_s, 0);
        check("r37_valid1", bus.res_valid1, 0);
        bus.add_out_ready = 1; bus.add_out_series = 1;
        @(negedge clk);
        bus.add_out_ready = 0; bus.add_out_series = 0; bus.add_s = '0;
        @(negedge clk);
        check("r37_late_valid1", bus.res_valid1, 0);
        check("r37_late_busy", bus.busy, 0);

`ifdef VECTOR_ADD_ARBITER_TIMEOUT_EN
        begin
            int n;
            bit seen;
            seen = 0; n = 0;
            bus.req0 = 1;
            waitAck("r38_ack", who);
            bus.req0 = 0;
            waitInReady("r38_in_ready");
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                n++;
                if (timeout_err) seen = 1;
            end
            if (!seen) failTimeout("r38_timeout");
            else begin
                check("r38_cycles", n, TO);
                check("r38_busy", bus.busy, 0);
                check("r38_valid0", bus.res_valid0, 0);
            end
        end
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_add_arbiter.md
VECTOR_ADD_ARBITER -- requirements
Module: vector_add_arbiter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 10, the signed element width of operands.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the watchdog limit in cycles (8-bit max).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  clock enable; when low, all registers hold and no outputs pulse.
REQ-006 req0, req1  input  1 each  level requests from client 0 and client 1.
REQ-007 a0_bus, b0_bus, a1_bus, b1_bus  input  10*IN_WIDTH each  client operand vectors; element k in bits [k*IN_WIDTH +: IN_WIDTH].
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: that client's operands captured.
REQ-009 add_ready  input  1  adder readyForNewDataSeries.
REQ-010 add_in_ready  output  1  one-cycle pulse to adder inReady.
REQ-011 add_a, add_b  output  10*IN_WIDTH each  registered operands to adder.
REQ-012 add_out_ready, add_out_series  input  1 each  adder half-result strobe and half index (0 = elements 0-4, 1 = elements 5-9).
REQ-013 add_s  input  5*(IN_WIDTH+1)  adder half-result, element j in bits [j*(IN_WIDTH+1) +: IN_WIDTH+1].
REQ-014 res_valid0, res_valid1  output  1 each  one-cycle pulse: full result for that client on res_s.
REQ-015 res_s  output  10*(IN_WIDTH+1)  assembled 10-element sum, held until next result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE; one operation outstanding at most.
REQ-018 IDLE: if any req and add_ready high, grant by round robin (last_grant toggles; client 0 first after reset), capture that client's buses into add_a/add_b, pulse ackN, record owner, go ISSUE.
REQ-019 Single requester SHALL be granted regardless of last_grant.
REQ-020 ISSUE: pulse add_in_ready for exactly one cycle, go WAIT_LO.
REQ-021 WAIT_LO: on add_out_ready with add_out_series=0, store add_s into res_s elements 0-4, go WAIT_HI; strobe with series=1 here SHALL be ignored.
REQ-022 WAIT_HI: on add_out_ready with add_out_series=1, store add_s into elements 5-9, go DONE.
REQ-023 DONE: pulse res_valid of owner for one cycle, update last_grant to owner, go IDLE; next grant earliest the following cycle.
REQ-024 Grant-to-ack latency 1 cycle after req seen in IDLE; ack-to-add_in_ready 1 cycle; last half strobe to res_valid 1 cycle.
REQ-025 Requests arriving while busy SHALL be held pending by the client's level; no queueing inside block.
REQ-026 add_a/add_b SHALL remain stable from ISSUE until return to IDLE.
REQ-027 No arithmetic in block; res_s widths pass through unmodified (IN_WIDTH+1 per element).

Reset
REQ-028 On reset: state IDLE, last_grant selects client 0 next, owner 0, add_a/add_b/res_s zero, ack0/ack1/add_in_ready/res_valid0/res_valid1/busy low, watchdog zero.
REQ-029 Reset mid-operation SHALL abandon the operation with no res_valid pulse; later adder strobes in IDLE are ignored.
REQ-030 Reset SHALL take effect regardless of enable.

Configuration
REQ-031 Macro VECTOR_ADD_ARBITER_TIMEOUT_EN: when defined, an 8-bit watchdog counts cycles in WAIT_LO/WAIT_HI, clears on each accepted strobe; on reaching TIMEOUT_CYCLES, FSM returns to IDLE without res_valid and output timeout_err (1 bit) pulses one cycle.
REQ-032 Without the macro, no watchdog, no timeout_err port; FSM waits in WAIT states indefinitely.

Verification
REQ-033 req0=1 only, a0 all 3, b0 all 4, adder model latency 2 -> ack0 one cycle later, add_in_ready next cycle, res_valid0 with all ten res_s elements = 7.
REQ-034 req0 and req1 both held after reset -> grant order 0,1,0,1; ack pulses never overlap; res_valid matches owner.
REQ-035 add_ready low while req1 high -> no ack1 until add_ready high; then ack1 next cycle.
REQ-036 Series=1 strobe first in WAIT_LO then series=0 then series=1 -> stray strobe ignored; result elements 5-9 from the last strobe.
REQ-037 Reset asserted in WAIT_HI -> next cycle busy=0, all outputs zero, no res_valid.
REQ-038 With VECTOR_ADD_ARBITER_TIMEOUT_EN, no adder strobes after issue -> timeout_err pulses after 255 cycles in WAIT_LO, busy drops, no res_valid.
